wb_grf: RTL and testbench
=========================

# wb_grf

Write-back stage and general register file for the five-stage MIPS pipeline. It consumes the registered outputs of the M/W pipeline register (instruction, ALU result, raw data-memory word, destination register, PC+4) and selects and extends the write-back value. It commits that value into a 32×32 register file and serves the two D-stage read ports with same-cycle write-through. It also exports the W-stage write value for the forwarding network and counts retired instructions.

## Interface
- No parameters; widths fixed by the MIPS ISA.
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears register file and counter.
- Instr_W  in  32  instruction held in M/W; 0 = bubble.
- ALU_Out_W  in  32  ALU/MD result; also the data-memory byte address.
- Data_out_dm_W  in  32  raw aligned word read from DM.
- WriteReg_W  in  5  destination register number.
- PC4_W  in  32  PC+4 of the W-stage instruction.
- RA1, RA2  in  5  D-stage read addresses.
- RD1, RD2  out  32  read data.
- WD_W  out  32  selected write-back value, to the forwarding muxes.
- WE_W  out  1  write enable actually applied this cycle.
- Retired_W  out  32  count of non-bubble instructions that reached W.

## Operation
- Source select from Instr_W opcode [31:26] and funct [5:0]:
  - Load group, opcodes 0x23 lw, 0x20 lb, 0x24 lbu, 0x21 lh, 0x25 lhu: WD = extended DM data.
  - jal (0x03) and jalr (opcode 0, funct 0x09): WD = PC4_W + 4, which is the return address past the delay slot.
  - R-type ALU, mfhi/mflo (funct 0x10/0x12), and I-type arithmetic/logic (0x08–0x0F): WD = ALU_Out_W.
  - All others, including stores, branches, j, jr, mult/div/mthi/mtlo, and bubble: no write.
- Load extension uses off = ALU_Out_W[1:0], little-endian:
  - lw: the full word; off ignored.
  - lb/lbu: byte at bits [8·off+7 : 8·off], sign- or zero-extended.
  - lh/lhu: half selected by off[1]; off[0] ignored; sign- or zero-extended.
- WE_W = writes-class AND WriteReg_W != 0. Register 0 is never written and always reads 0.
- Read ports:
  - RDx = 0 if RAx == 0.
  - Otherwise, if WE_W and RAx == WriteReg_W, RDx = WD_W (write-through).
  - Otherwise RDx = the stored register.
- Retired_W increments by 1 on each clk where Instr_W != 0. It wraps 0xFFFFFFFF → 0.

## Timing
- Reads and WD_W/WE_W are combinational from their inputs in the same cycle.
- A register write commits at the posedge that ends the cycle in which WE_W = 1. Write-through makes the value visible to D in that same cycle, giving zero-cycle effective latency.
- Reset:
  - At a posedge with reset = 1, all 32 registers become 0 and Retired_W becomes 0.
  - Any pending write that cycle is discarded; reset has priority.
  - Write-through is still combinationally active during the reset cycle.
- Reset mid-stream: state is lost after that edge. The next non-reset edge resumes normal writes.
- Simultaneous RA1 == RA2 == WriteReg_W: both ports return WD_W.
- Back-to-back writes to the same register: the later one wins at its own edge.

## Structure
- Shared package mips_defs holds opcode/funct localparams (OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_JAL, FN_JALR, FN_MFHI, FN_MFLO, ...). The M/W, E, and D stages reuse it.
- Sub-module load_ext: combinational byte/half selection and extension. Inputs are instruction class, off, and raw word; output is a 32-bit value.
- Top holds the register array, write-back mux, bypass, and retire counter.

## Test plan
- addiu-class writeback: Instr_W = 0x2408_1234 (opcode 0x09), ALU_Out_W = 0x1234, WriteReg_W = 8 -> WE_W = 1, WD_W = 0x1234. RA1 = 8 gives 0x1234 in the same cycle and 0x1234 from storage after the edge.
- Loads: Data_out_dm_W = 0x8001_F27F, ALU_Out_W[1:0] = 1.
  - lb -> WD 0xFFFF_FFF2; lbu -> 0x0000_00F2.
  - With off = 2: lh -> 0xFFFF_8001; lhu -> 0x0000_8001.
  - lw -> 0x8001_F27F.
- jal with PC4_W = 0x0000_3004 -> WriteReg 31 gets 0x0000_3008.
- $0 protection: R-type with WriteReg_W = 0, ALU_Out_W = 0xDEAD_BEEF -> WE_W = 0, RD1(RA1 = 0) = 0 before and after the edge.
- Reset priority: write $5 = 7, then assert reset together with a write of $5 = 9 -> after the edge, RD($5) = 0 and Retired_W = 0.
- Counter: 3 non-zero instructions, 1 bubble (Instr_W = 0), then 2 non-zero instructions -> Retired_W = 5.

Source files
------------

// File: rtl/mips_defs.sv
// Opcode/funct encodings and write-back decode shared by the MIPS pipeline stages.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_BREAK   = 6'h0D;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;

  typedef enum logic [1:0] {SrcNone, SrcAlu, SrcMem, SrcLink} wb_src_e;
  typedef enum logic [2:0] {LdW, LdB, LdBu, LdH, LdHu} ld_kind_e;

  function automatic wb_src_e decode_wb_src(logic [31:0] instr);
    logic [5:0] op;
    logic [5:0] fn;
    wb_src_e    src;
    op  = instr[31:26];
    fn  = instr[5:0];
    src = SrcNone;
    if (instr != 32'h0) begin
      case (op)
        OP_RTYPE: begin
          case (fn)
            FN_JALR: src = SrcLink;
            FN_JR, FN_SYSCALL, FN_BREAK, FN_MTHI, FN_MTLO,
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: src = SrcNone;
            default: src = SrcAlu;  // ALU ops plus mfhi/mflo
          endcase
        end
        OP_JAL: src = SrcLink;
        OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: src = SrcMem;
        default: src = (op[5:3] == 3'b001) ? SrcAlu : SrcNone;  // 0x08-0x0F immediates
      endcase
    end
    return src;
  endfunction

  function automatic ld_kind_e decode_ld_kind(logic [5:0] op);
    ld_kind_e kind;
    case (op)
      OP_LB:   kind = LdB;
      OP_LBU:  kind = LdBu;
      OP_LH:   kind = LdH;
      OP_LHU:  kind = LdHu;
      default: kind = LdW;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/wb_grf_if.sv
// W-stage inputs and register-file read/write-back outputs of the wb_grf block.
interface wb_grf_if;
  logic [31:0] Instr_W;
  logic [31:0] ALU_Out_W;
  logic [31:0] Data_out_dm_W;
  logic [4:0]  WriteReg_W;
  logic [31:0] PC4_W;
  logic [4:0]  RA1;
  logic [4:0]  RA2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] WD_W;
  logic        WE_W;
  logic [31:0] Retired_W;

  modport master (
    output Instr_W, ALU_Out_W, Data_out_dm_W, WriteReg_W, PC4_W, RA1, RA2,
    input  RD1, RD2, WD_W, WE_W, Retired_W
  );

  modport slave (
    input  Instr_W, ALU_Out_W, Data_out_dm_W, WriteReg_W, PC4_W, RA1, RA2,
    output RD1, RD2, WD_W, WE_W, Retired_W
  );
endinterface

// File: rtl/load_ext.sv
// Little-endian byte/half selection and sign/zero extension of a loaded word.
module load_ext
  import mips_defs::*;
(
  input  ld_kind_e    kind,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[8*off +: 8];
    half_sel = off[1] ? word[31:16] : word[15:0];
    unique case (kind)
      LdB:     ext = {{24{byte_sel[7]}}, byte_sel};
      LdBu:    ext = {24'h0, byte_sel};
      LdH:     ext = {{16{half_sel[15]}}, half_sel};
      LdHu:    ext = {16'h0, half_sel};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/wb_grf.sv
// Write-back select, 32x32 register file with write-through reads, and retire counter.
module wb_grf
  import mips_defs::*;
(
  input logic     clk,
  input logic     reset,
  wb_grf_if.slave bus
);

  logic [31:0] rf_q [32];
  logic [31:0] retired_q;
  wb_src_e     src;
  ld_kind_e    kind;
  logic [31:0] load_val;
  logic [31:0] wd;
  logic        we;

  load_ext u_load_ext (
    .kind (kind),
    .off  (bus.ALU_Out_W[1:0]),
    .word (bus.Data_out_dm_W),
    .ext  (load_val)
  );

  always_comb begin
    src  = decode_wb_src(bus.Instr_W);
    kind = decode_ld_kind(bus.Instr_W[31:26]);
    unique case (src)
      SrcMem:  wd = load_val;
      SrcLink: wd = bus.PC4_W + 32'd4;  // return address skips the delay slot
      SrcAlu:  wd = bus.ALU_Out_W;
      default: wd = 32'h0;
    endcase
    we = (src != SrcNone) && (bus.WriteReg_W != 5'd0);
  end

  always_comb begin
    if (bus.RA1 == 5'd0)                      bus.RD1 = 32'h0;
    else if (we && bus.RA1 == bus.WriteReg_W) bus.RD1 = wd;
    else                                      bus.RD1 = rf_q[bus.RA1];
    if (bus.RA2 == 5'd0)                      bus.RD2 = 32'h0;
    else if (we && bus.RA2 == bus.WriteReg_W) bus.RD2 = wd;
    else                                      bus.RD2 = rf_q[bus.RA2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
      retired_q <= 32'h0;
    end else begin
      if (we) rf_q[bus.WriteReg_W] <= wd;
      if (bus.Instr_W != 32'h0) retired_q <= retired_q + 32'd1;
    end
  end

  assign bus.WD_W      = wd;
  assign bus.WE_W      = we;
  assign bus.Retired_W = retired_q;

endmodule

// File: tb/tb_wb_grf.sv
// Directed self-checking bench for wb_grf.
module tb_wb_grf;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  wb_grf_if bus ();

  wb_grf dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] dm,
                       input logic [4:0] wr, input logic [31:0] pc4);
    bus.Instr_W       = instr;
    bus.ALU_Out_W     = alu;
    bus.Data_out_dm_W = dm;
    bus.WriteReg_W    = wr;
    bus.PC4_W         = pc4;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    bus.RA1 = 5'd8;
    bus.RA2 = 5'd9;
    drive(32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_retired", bus.Retired_W, 32'h0);
    chk("reset_rd1", bus.RD1, 32'h0);
    chk("bubble_we", {31'h0, bus.WE_W}, 32'h0);

    // addiu $8 = 0x1234
    drive(32'h2408_1234, 32'h0000_1234, 32'h0, 5'd8, 32'h0);
    #1;
    chk("addiu_we", {31'h0, bus.WE_W}, 32'h1);
    chk("addiu_wd", bus.WD_W, 32'h0000_1234);
    chk("addiu_bypass", bus.RD1, 32'h0000_1234);
    tick();
    drive(32'h0, 32'h0, 32'h0, 5'd8, 32'h0);
    #1;
    chk("addiu_stored", bus.RD1, 32'h0000_1234);
    chk("retired_one", bus.Retired_W, 32'h1);

    // Loads
    drive(32'h8000_0000, 32'h0000_1001, 32'h8001_F27F, 5'd9, 32'h0);
    #1;
    chk("lb_wd", bus.WD_W, 32'hFFFF_FFF2);
    drive(32'h9000_0000, 32'h0000_1001, 32'h8001_F27F, 5'd9, 32'h0);
    #1;
    chk("lbu_wd", bus.WD_W, 32'h0000_00F2);
    drive(32'h8400_0000, 32'h0000_1002, 32'h8001_F27F, 5'd9, 32'h0);
    #1;
    chk("lh_wd", bus.WD_W, 32'hFFFF_8001);
    drive(32'h9400_0000, 32'h0000_1002, 32'h8001_F27F, 5'd9, 32'h0);
    #1;
    chk("lhu_wd", bus.WD_W, 32'h0000_8001);
    drive(32'h8400_0000, 32'h0000_1000, 32'h8001_F27F, 5'd9, 32'h0);
    #1;
    chk("lh_lo_wd", bus.WD_W, 32'hFFFF_F27F);
    drive(32'h9000_0000, 32'h0000_1003, 32'h8001_F27F, 5'd9, 32'h0);
    #1;
    chk("lbu_off3_wd", bus.WD_W, 32'h0000_0080);
    drive(32'h8C00_0000, 32'h0000_1003, 32'h8001_F27F, 5'd9, 32'h0);
    #1;
    chk("lw_wd", bus.WD_W, 32'h8001_F27F);
    tick();
    drive(32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
    #1;
    chk("lw_stored", bus.RD2, 32'h8001_F27F);

    // jal / jalr link
    bus.RA1 = 5'd31;
    drive(32'h0C00_0000, 32'h0, 32'h0, 5'd31, 32'h0000_3004);
    #1;
    chk("jal_wd", bus.WD_W, 32'h0000_3008);
    tick();
    drive(32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
    #1;
    chk("jal_stored", bus.RD1, 32'h0000_3008);
    drive(32'h03E0_F809, 32'h0, 32'h0, 5'd31, 32'h0000_0100);
    #1;
    chk("jalr_wd", bus.WD_W, 32'h0000_0104);
    chk("jalr_we", {31'h0, bus.WE_W}, 32'h1);

    // Non-writing classes and mfhi
    drive(32'hAC00_0000, 32'h0000_0044, 32'h0, 5'd9, 32'h0);
    #1;
    chk("sw_we", {31'h0, bus.WE_W}, 32'h0);
    drive(32'h0000_0018, 32'h0000_0044, 32'h0, 5'd5, 32'h0);
    #1;
    chk("mult_we", {31'h0, bus.WE_W}, 32'h0);
    drive(32'h0000_0010, 32'h0000_0055, 32'h0, 5'd5, 32'h0);
    #1;
    chk("mfhi_we", {31'h0, bus.WE_W}, 32'h1);
    chk("mfhi_wd", bus.WD_W, 32'h0000_0055);

    // $0 protection
    bus.RA1 = 5'd0;
    drive(32'h0000_0021, 32'hDEAD_BEEF, 32'h0, 5'd0, 32'h0);
    #1;
    chk("r0_we", {31'h0, bus.WE_W}, 32'h0);
    chk("r0_rd_before", bus.RD1, 32'h0);
    tick();
    #1;
    chk("r0_rd_after", bus.RD1, 32'h0);

    // Both ports bypass the same register
    bus.RA1 = 5'd10;
    bus.RA2 = 5'd10;
    drive(32'h0000_0021, 32'h0000_A5A5, 32'h0, 5'd10, 32'h0);
    #1;
    chk("dual_rd1", bus.RD1, 32'h0000_A5A5);
    chk("dual_rd2", bus.RD2, 32'h0000_A5A5);

    // Reset beats a pending write
    bus.RA1 = 5'd5;
    drive(32'h0000_0021, 32'h0000_0007, 32'h0, 5'd5, 32'h0);
    tick();
    drive(32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
    #1;
    chk("r5_written", bus.RD1, 32'h0000_0007);
    reset = 1'b1;
    drive(32'h0000_0021, 32'h0000_0009, 32'h0, 5'd5, 32'h0);
    #1;
    chk("reset_bypass", bus.RD1, 32'h0000_0009);
    tick();
    reset = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
    #1;
    chk("reset_r5", bus.RD1, 32'h0);
    chk("reset_retired2", bus.Retired_W, 32'h0);

    // Counter with a bubble; back-to-back writes to $6
    bus.RA1 = 5'd6;
    drive(32'h0000_0021, 32'h0000_0001, 32'h0, 5'd6, 32'h0);
    tick();
    drive(32'h0000_0021, 32'h0000_0002, 32'h0, 5'd6, 32'h0);
    tick();
    drive(32'hAC00_0000, 32'h0, 32'h0, 5'd0, 32'h0);
    tick();
    drive(32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
    tick();
    #1;
    chk("retired_bubble", bus.Retired_W, 32'h3);
    drive(32'hAC00_0000, 32'h0, 32'h0, 5'd0, 32'h0);
    tick();
    tick();
    drive(32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
    #1;
    chk("retired_five", bus.Retired_W, 32'h5);
    chk("b2b_r6", bus.RD1, 32'h0000_0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
